// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the three buses around the memory arbiter.
//   IF port : if_req/if_addr in, if_gnt/if_rvalid/if_rdata out
//   LS port : ls_req/ls_we/ls_addr/ls_wdata in, ls_gnt/ls_rvalid/ls_rdata out
//   MEM port: mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ack in
//   err     : timeout flag, pulses together with an rvalid
// Modports: slave = the arbiter's view, master = the surrounding system.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        err;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ack,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ack,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (IF) and
// load/store (LS). LS has fixed priority; after STARVE_MAX consecutive LS
// grants made while IF was waiting, IF is forced to win. One memory
// transaction is outstanding at a time.
//
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   bus (slave)     : IF, LS and memory buses plus err (see mem_arbiter_if)
//   dbg_state       : current FSM state (IDLE=0, BUSY_IF=1, BUSY_LS=2)
//   dbg_starve_cnt  : consecutive LS-over-waiting-IF grant count
//
// Handshake: a requester holds x_req (and its address/data) until it sees
// the one-cycle x_gnt pulse; a req still high in the following IDLE cycle
// is a new request. The memory sees mem_req held with stable mem_we /
// mem_addr / mem_wdata until mem_ack is sampled high at a rising edge; the
// result comes back as a one-cycle x_rvalid pulse one cycle later.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a transaction after
// TIMEOUT busy cycles without mem_ack (x_rvalid + err, rdata 32'hDEAD_BEEF).
// Without it BUSY waits indefinitely and err stays 0.
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst,
  mem_arbiter_if.slave bus,
  output logic [1:0] dbg_state,
  output logic [3:0] dbg_starve_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_IF = 2'd1;
  localparam logic [1:0] BUSY_LS = 2'd2;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("mem_arbiter: STARVE_MAX must be 1..15 and TIMEOUT 1..255");
  end

  logic [1:0] state;
  logic [3:0] starve_cnt;

`ifdef MEM_ARB_TIMEOUT_EN
  // wait_cnt counts completed busy cycles without mem_ack; the cycle in
  // which it already equals TIMEOUT-1 is the TIMEOUT-th such cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
`endif

  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      starve_cnt    <= 4'd0;
      bus.if_gnt    <= 1'b0;
      bus.if_rvalid <= 1'b0;
      bus.if_rdata  <= 32'd0;
      bus.ls_gnt    <= 1'b0;
      bus.ls_rvalid <= 1'b0;
      bus.ls_rdata  <= 32'd0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'd0;
      bus.mem_wdata <= 32'd0;
      bus.err       <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_cnt      <= 8'd0;
`endif
    end else begin
      // Pulses last exactly one cycle.
      bus.if_gnt    <= 1'b0;
      bus.ls_gnt    <= 1'b0;
      bus.if_rvalid <= 1'b0;
      bus.ls_rvalid <= 1'b0;
      bus.err       <= 1'b0;

      case (state)
        IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
          wait_cnt <= 8'd0;
`endif
          if (bus.ls_req && (!bus.if_req || starve_cnt < STARVE_LIM)) begin
            state         <= BUSY_LS;
            bus.ls_gnt    <= 1'b1;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.ls_we;
            bus.mem_addr  <= bus.ls_addr;
            bus.mem_wdata <= bus.ls_wdata;
            // Only LS wins that actually held off a waiting IF count.
            if (bus.if_req && starve_cnt < STARVE_LIM)
              starve_cnt <= starve_cnt + 4'd1;
          end else if (bus.if_req) begin
            state         <= BUSY_IF;
            bus.if_gnt    <= 1'b1;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.if_addr;
            bus.mem_wdata <= 32'd0;
            starve_cnt    <= 4'd0;
          end
        end

        BUSY_IF, BUSY_LS: begin
          if (bus.mem_ack) begin
            state       <= IDLE;
            bus.mem_req <= 1'b0;
            if (state == BUSY_IF) begin
              bus.if_rvalid <= 1'b1;
              bus.if_rdata  <= bus.mem_rdata;
            end else begin
              bus.ls_rvalid <= 1'b1;
              bus.ls_rdata  <= bus.mem_we ? 32'd0 : bus.mem_rdata;
            end
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_LAST) begin
            state       <= IDLE;
            bus.mem_req <= 1'b0;
            bus.err     <= 1'b1;
            if (state == BUSY_IF) begin
              bus.if_rvalid <= 1'b1;
              bus.if_rdata  <= 32'hDEAD_BEEF;
            end else begin
              bus.ls_rvalid <= 1'b1;
              bus.ls_rdata  <= 32'hDEAD_BEEF;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end

        default: begin
          state       <= IDLE;
          bus.mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by randomized IF/LS traffic
// against a transaction-level arbitration model. The model pushes expected
// grants and responses (with their expected cycle) into queues; a monitor
// pops and compares whenever the DUT pulses a gnt or rvalid.
module tb_mem_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 8;
  localparam int GW = 98;  // {port, we, addr, wdata, cyc}
  localparam int RW = 66;  // {port, err, data, cyc}

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  logic [3:0] dbg_starve_cnt;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [GW-1:0] exp_g[$];
  logic [RW-1:0] exp_r[$];
  bit   gnt_log[$];       // 1 = LS grant, 0 = IF grant, in order seen
  int   req_len = 0;      // mem_req-high cycles of the current transaction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- memory responder ----------------
  bit          ack_en = 1'b1;
  bit          spurious_en = 1'b0;
  bit          fixed_rdata_en = 1'b0;
  logic [31:0] fixed_rdata = 32'd0;
  int          fixed_wait = 0;   // <0 = random wait 0..4
  int          left = 0;

  always @(negedge clk) begin
    if (rst) begin
      bus.mem_ack = 1'b0;
      left = 0;
    end else if (bus.mem_req) begin
      if (ack_en && left == 0) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = fixed_rdata_en ? fixed_rdata : $urandom;
      end else begin
        bus.mem_ack = 1'b0;
        if (left > 0) left--;
      end
    end else begin
      bus.mem_ack   = spurious_en && ($urandom_range(0, 3) == 0);
      bus.mem_rdata = $urandom;
      left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 4));
    end
  end

  // ---------------- reference model ----------------
  // One transaction at a time: when idle, the sampled requests pick a
  // winner; the result is due the cycle after mem_ack is sampled.
  bit          m_busy = 1'b0;
  bit          m_port = 1'b0;
  bit          m_we = 1'b0;
  int          m_starve = 0;
  int          m_wait = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_starve = 0;
      m_wait = 0;
      exp_g.delete();
      exp_r.delete();
    end else if (m_busy) begin
      if (bus.mem_ack) begin
        exp_r.push_back({m_port, 1'b0, (m_port && m_we) ? 32'd0 : bus.mem_rdata, cyc + 1});
        m_busy = 1'b0;
      end
`ifdef MEM_ARB_TIMEOUT_EN
      else begin
        m_wait++;
        if (m_wait == TIMEOUT) begin
          exp_r.push_back({m_port, 1'b1, 32'hDEAD_BEEF, cyc + 1});
          m_busy = 1'b0;
        end
      end
`endif
    end else begin
      m_wait = 0;
      if (bus.ls_req && (!bus.if_req || m_starve < STARVE_MAX)) begin
        m_busy = 1'b1; m_port = 1'b1; m_we = bus.ls_we;
        exp_g.push_back({1'b1, bus.ls_we, bus.ls_addr, bus.ls_wdata, cyc + 1});
        if (bus.if_req) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
      end else if (bus.if_req) begin
        m_busy = 1'b1; m_port = 1'b0; m_we = 1'b0;
        exp_g.push_back({1'b0, 1'b0, bus.if_addr, 32'd0, cyc + 1});
        m_starve = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [GW-1:0] g;
  logic [RW-1:0] r;
  logic          h_we;
  logic [31:0]   h_addr, h_wdata;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.if_gnt || bus.ls_gnt) begin
        if (bus.if_gnt && bus.ls_gnt) check("dual_gnt", 32'd1, 32'd0);
        gnt_log.push_back(bus.ls_gnt);
        req_len = 1;
        if (exp_g.size() == 0) begin
          check("unexpected_gnt", 32'd1, 32'd0);
        end else begin
          g = exp_g.pop_front();
          check("gnt_port",  {31'd0, bus.ls_gnt}, {31'd0, g[97]});
          check("gnt_cycle", cyc, g[31:0]);
          check("mem_req",   {31'd0, bus.mem_req}, 32'd1);
          check("mem_we",    {31'd0, bus.mem_we}, {31'd0, g[96]});
          check("mem_addr",  bus.mem_addr, g[95:64]);
          check("mem_wdata", bus.mem_wdata, g[63:32]);
          h_we = g[96]; h_addr = g[95:64]; h_wdata = g[63:32];
        end
      end else if (bus.mem_req) begin
        req_len++;
        check("hold_we",    {31'd0, bus.mem_we}, {31'd0, h_we});
        check("hold_addr",  bus.mem_addr, h_addr);
        check("hold_wdata", bus.mem_wdata, h_wdata);
      end
      if (bus.if_rvalid || bus.ls_rvalid) begin
        if (bus.if_rvalid && bus.ls_rvalid) check("dual_rvalid", 32'd1, 32'd0);
        if (exp_r.size() == 0) begin
          check("unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          r = exp_r.pop_front();
          check("rvalid_port",  {31'd0, bus.ls_rvalid}, {31'd0, r[65]});
          check("rvalid_cycle", cyc, r[31:0]);
          check("rdata", bus.ls_rvalid ? bus.ls_rdata : bus.if_rdata, r[63:32]);
          check("err", {31'd0, bus.err}, {31'd0, r[64]});
        end
      end else if (bus.err) begin
        check("err_without_rvalid", 32'd1, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_for(input string name, input int sel);
    bit hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0: hit = bus.if_gnt;
        1: hit = bus.ls_gnt;
        2: hit = bus.if_rvalid;
        default: hit = bus.ls_rvalid;
      endcase
    end
    if (!hit) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"},   {31'd0, bus.mem_req}, 32'd0);
    check({tag, "_gnts"},      {30'd0, bus.if_gnt, bus.ls_gnt}, 32'd0);
    check({tag, "_rvalids"},   {30'd0, bus.if_rvalid, bus.ls_rvalid}, 32'd0);
    check({tag, "_if_rdata"},  bus.if_rdata, 32'd0);
    check({tag, "_ls_rdata"},  bus.ls_rdata, 32'd0);
    check({tag, "_mem_addr"},  bus.mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    check({tag, "_mem_we"},    {31'd0, bus.mem_we}, 32'd0);
    check({tag, "_err"},       {31'd0, bus.err}, 32'd0);
    check({tag, "_state"},     {30'd0, dbg_state}, 32'd0);
    check({tag, "_starve"},    {28'd0, dbg_starve_cnt}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int          s;
  int unsigned rel_cyc;
  bit          seq_ok;

  initial begin
    bus.if_req = 0; bus.if_addr = 0;
    bus.ls_req = 0; bus.ls_we = 0; bus.ls_addr = 0; bus.ls_wdata = 0;
    bus.mem_ack = 0; bus.mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst = 1'b0;

    // Single fetch, memory answers in the first mem_req cycle.
    fixed_wait = 0; fixed_rdata_en = 1'b1; fixed_rdata = 32'h0000_0013;
    bus.if_req = 1; bus.if_addr = 32'h0000_0040;
    wait_for("fetch_gnt", 0);
    bus.if_req = 0;
    wait_for("fetch_rvalid", 2);
    check("fetch_rdata", bus.if_rdata, 32'h0000_0013);
    fixed_rdata_en = 1'b0;
    idle_cycles(2);

    // Contention: LS store beats IF, IF follows.
    s = gnt_log.size();
    bus.if_req = 1; bus.if_addr = 32'h0000_0300;
    bus.ls_req = 1; bus.ls_we = 1; bus.ls_addr = 32'h0000_2000; bus.ls_wdata = 32'hCAFE_F00D;
    wait_for("cont_ls_gnt", 1);
    bus.ls_req = 0; bus.ls_we = 0;
    wait_for("cont_if_gnt", 0);
    bus.if_req = 0;
    wait_for("cont_if_rvalid", 2);
    check("store_ls_rdata", bus.ls_rdata, 32'd0);
    if (gnt_log.size() >= s + 2) begin
      check("cont_first", {31'd0, gnt_log[s]}, 32'd1);
      check("cont_second", {31'd0, gnt_log[s + 1]}, 32'd0);
    end else check("cont_gnt_count", gnt_log.size() - s, 32'd2);
    idle_cycles(2);

    // Starvation guard: both held, four LS wins then IF, then LS again.
    s = gnt_log.size();
    bus.if_req = 1; bus.if_addr = 32'h0000_0400;
    bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 32'h0000_3000;
    for (int i = 0; i < 100 && gnt_log.size() < s + 6; i++) @(negedge clk);
    bus.if_req = 0; bus.ls_req = 0;
    idle_cycles(6);
    if (gnt_log.size() >= s + 6) begin
      seq_ok = 1'b1;
      for (int i = 0; i < 6; i++) if (gnt_log[s + i] != (i != 4)) seq_ok = 1'b0;
      check("starve_sequence", {31'd0, seq_ok}, 32'd1);
    end else check("starve_gnt_count", gnt_log.size() - s, 32'd6);

    // Wait states: ack after 5 extra cycles, mem_req high for 6.
    fixed_wait = 5;
    bus.ls_req = 1; bus.ls_we = 1; bus.ls_addr = 32'h0000_4000; bus.ls_wdata = $urandom;
    wait_for("wait_gnt", 1);
    bus.ls_req = 0; bus.ls_we = 0;
    wait_for("wait_rvalid", 3);
    check("wait_req_len", req_len, 32'd6);
    fixed_wait = 0;
    idle_cycles(2);

    // Memory never answers.
    ack_en = 1'b0;
    bus.if_req = 1; bus.if_addr = 32'h0000_0500;
    wait_for("to_gnt", 0);
    bus.if_req = 0;
`ifdef MEM_ARB_TIMEOUT_EN
    wait_for("to_rvalid", 2);
    check("to_err", {31'd0, bus.err}, 32'd1);
    check("to_rdata", bus.if_rdata, 32'hDEAD_BEEF);
    check("to_len", req_len, 32'(TIMEOUT));
    ack_en = 1'b1;
`else
    idle_cycles(20);
    check("noto_mem_req", {31'd0, bus.mem_req}, 32'd1);
    check("noto_err", {31'd0, bus.err}, 32'd0);
    ack_en = 1'b1;
    wait_for("noto_rvalid", 2);
`endif
    idle_cycles(2);

    // Reset in the middle of an unanswered fetch.
    ack_en = 1'b0;
    bus.if_req = 1; bus.if_addr = 32'h0000_0100;
    wait_for("rst_gnt", 0);
    idle_cycles(3);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    idle_cycles(2);
    rst = 1'b0;
    rel_cyc = cyc;
    ack_en = 1'b1;
    wait_for("regrant", 0);
    check("regrant_cycle", cyc, rel_cyc + 1);
    bus.if_req = 0;
    wait_for("regrant_rvalid", 2);
    idle_cycles(2);

    // Randomized traffic.
    fixed_wait = -1; spurious_en = 1'b1;
    repeat (2000) begin
      @(negedge clk);
      if (!bus.if_req || bus.if_gnt) begin
        bus.if_req = ($urandom_range(0, 2) != 0);
        bus.if_addr = $urandom;
      end
      if (!bus.ls_req || bus.ls_gnt) begin
        bus.ls_req = ($urandom_range(0, 2) != 0);
        bus.ls_we = $urandom_range(0, 1);
        bus.ls_addr = $urandom;
        bus.ls_wdata = $urandom;
      end
    end
    @(negedge clk);
    bus.if_req = 0; bus.ls_req = 0; spurious_en = 1'b0;
    for (int i = 0; i < 50 && (m_busy || exp_r.size() != 0); i++) @(negedge clk);
    idle_cycles(3);
    check("left_gnt", exp_g.size(), 32'd0);
    check("left_rvalid", exp_r.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
